// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings,
// FSM state type and the access-size decode helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, READ} dmem_state_t;

  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} dmem_size_t;

  // Low two funct3 bits pick the size; 011/110/111 fall through to word.
  function automatic dmem_size_t f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SzByte;
      2'b01:   return SzHalf;
      default: return SzWord;
    endcase
  endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are not reset.
module dmem_sram #(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned AddrW      = $clog2(DepthWords)
) (
  input  logic             clk,
  input  logic [3:0]       i_be,
  input  logic             i_re,
  input  logic [AddrW-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DepthWords];
  logic [31:0] r_rdata;

  // Byte-lane writes and registered read.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder for the RV32I pipeline. Stores complete in
// zero stall cycles; loads take one busy cycle and return extended data in READ.
// Optional DMEM_MISALIGN_TRAP_EN: detect misaligned H/W accesses, suppress the
// store / zero the load, and pulse MemErrM the cycle after acceptance.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic        MemErrM,
`endif
  output logic        MemBusyM
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  dmem_state_t       r_state, w_state_next;
  logic [1:0]        r_off;
  logic [2:0]        r_f3;
  logic [31:0]       r_hold;

  logic [1:0]        w_off;
  logic [ADDR_W-1:0] w_idx;
  dmem_size_t        w_size;
  logic              w_idle, w_store, w_load;
  logic [3:0]        w_be_raw, w_be;
  logic [31:0]       w_wdata, w_rdata, w_ext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic              w_unused_addr;

  assign w_off  = ALUResultM[1:0];
  assign w_idx  = ALUResultM[ADDR_W+1:2];
  assign w_size = f3_size(Funct3M);
  // Upper address bits are deliberately dropped: the space wraps.
  assign w_unused_addr = ^ALUResultM[31:ADDR_W+2];

  // Acceptance is gated by reset so nothing is written or stalled while held.
  assign w_idle  = (r_state == IDLE) && !reset;
  assign w_store = w_idle && MemReqM && MemWriteM;
  assign w_load  = w_idle && MemReqM && !MemWriteM;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic w_mis, r_mis, r_err;
  assign w_mis = ((w_size == SzHalf) && w_off[0]) || ((w_size == SzWord) && (w_off != 2'b00));
  assign w_be  = (w_store && !w_mis) ? w_be_raw : 4'b0000;
  assign MemErrM = r_err;

  // Misalignment flag for the pending load and the one-cycle error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mis <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_err <= (w_store || w_load) && w_mis;
      if (w_load) r_mis <= w_mis;
    end
  end
`else
  assign w_be = w_store ? w_be_raw : 4'b0000;
`endif

  // Store lane enables and replicated write data; halfword uses offset[1] only.
  always_comb begin
    w_be_raw = 4'b1111;
    w_wdata  = WriteDataM;
    case (w_size)
      SzByte: begin
        w_be_raw = 4'b0001 << w_off;
        w_wdata  = {4{WriteDataM[7:0]}};
      end
      SzHalf: begin
        w_be_raw = w_off[1] ? 4'b1100 : 4'b0011;
        w_wdata  = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be_raw = 4'b1111;
        w_wdata  = WriteDataM;
      end
    endcase
  end

  dmem_sram #(
    .DepthWords (DEPTH_WORDS),
    .AddrW      (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .i_be    (w_be),
    .i_re    (w_load),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and stall: busy only while a load waits in IDLE.
  always_comb begin
    w_state_next = r_state;
    MemBusyM     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_next = READ;
          MemBusyM     = 1'b1;
        end
      end
      READ:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Latch load offset/size at acceptance; hold last returned data after READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off  <= 2'b00;
      r_f3   <= F3_W;
      r_hold <= 32'h0;
    end else begin
      if (w_load) begin
        r_off <= w_off;
        r_f3  <= Funct3M;
      end
      if (r_state == READ) r_hold <= w_ext;
    end
  end

  assign w_byte = w_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? w_rdata[31:16] : w_rdata[15:0];

  // Lane select and sign/zero extension of the registered read word.
  always_comb begin
    w_ext = w_rdata;
    case (f3_size(r_f3))
      SzByte:  w_ext = r_f3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SzHalf:  w_ext = r_f3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ext = w_rdata;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    if (r_mis) w_ext = 32'h0;
`endif
  end

  assign ReadDataM = (r_state == READ) ? w_ext : r_hold;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder. Inputs change on the falling
// edge; outputs are sampled away from the rising edge.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        MemBusyM;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        MemErrM;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (1024)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
`ifdef DMEM_MISALIGN_TRAP_EN
    .MemErrM    (MemErrM),
`endif
    .MemBusyM   (MemBusyM)
  );

  // Called at a falling edge in IDLE; returns at the next falling edge.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] f3, output logic busy);
    MemReqM = 1'b1; MemWriteM = 1'b1; ALUResultM = addr; WriteDataM = data; Funct3M = f3;
    #1 busy = MemBusyM;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0; MemWriteM = 1'b0;
  endtask

  // Load held in M across its IDLE and READ cycles; returns at falling edge in IDLE.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, output logic [31:0] data,
                         output logic busy_req, output logic busy_rd);
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = addr; WriteDataM = 32'h0; Funct3M = f3;
    #1 busy_req = MemBusyM;
    @(posedge clk); @(negedge clk);
    busy_rd = MemBusyM;
    data    = ReadDataM;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = F3_W;
    ALUResultM = 32'h10; WriteDataM = 32'h0;
    repeat (2) @(negedge clk);
    n_total++;
    if (ReadDataM !== 32'h0) $display("FAIL reset_rdata: got %h want %h", ReadDataM, 32'h0);
    else n_pass++;
    n_total++;
    if (MemBusyM !== 1'b0) $display("FAIL reset_busy: got %b want 0", MemBusyM);
    else n_pass++;
    reset = 1'b0; MemReqM = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic b0, b1; logic [31:0] d;
    do_store(32'h10, 32'hDEADBEEF, F3_W, b0);
    n_total++;
    if (b0 !== 1'b0) $display("FAIL sw_busy: got %b want 0", b0);
    else n_pass++;
    do_load(32'h10, F3_W, d, b0, b1);
    n_total++;
    if ({b0, b1} !== 2'b10) $display("FAIL lw_busy: got %b want 10", {b0, b1});
    else n_pass++;
    n_total++;
    if (d !== 32'hDEADBEEF) $display("FAIL lw_data: got %h want deadbeef", d);
    else n_pass++;
    #1;
    n_total++;
    if (ReadDataM !== 32'hDEADBEEF) $display("FAIL rdata_hold: got %h want deadbeef", ReadDataM);
    else n_pass++;
  endtask

  task automatic test_byte();
    logic b0, b1; logic [31:0] d;
    do_store(32'h13, 32'h12345680, F3_B, b0);
    do_load(32'h13, F3_B, d, b0, b1);
    n_total++;
    if (d !== 32'hFFFFFF80) $display("FAIL lb: got %h want ffffff80", d);
    else n_pass++;
    do_load(32'h13, F3_BU, d, b0, b1);
    n_total++;
    if (d !== 32'h00000080) $display("FAIL lbu: got %h want 00000080", d);
    else n_pass++;
    do_load(32'h10, F3_W, d, b0, b1);
    n_total++;
    if (d !== 32'h80ADBEEF) $display("FAIL sb_word: got %h want 80adbeef", d);
    else n_pass++;
  endtask

  task automatic test_half();
    logic b0, b1; logic [31:0] d;
    do_store(32'h20, 32'h11223344, F3_W, b0);
    do_store(32'h22, 32'hABCD8001, F3_H, b0);
    do_load(32'h22, F3_H, d, b0, b1);
    n_total++;
    if (d !== 32'hFFFF8001) $display("FAIL lh: got %h want ffff8001", d);
    else n_pass++;
    do_load(32'h22, F3_HU, d, b0, b1);
    n_total++;
    if (d !== 32'h00008001) $display("FAIL lhu: got %h want 00008001", d);
    else n_pass++;
    do_load(32'h20, F3_HU, d, b0, b1);
    n_total++;
    if (d !== 32'h00003344) $display("FAIL sh_low_kept: got %h want 00003344", d);
    else n_pass++;
    do_load(32'h20, 3'b011, d, b0, b1);
    n_total++;
    if (d !== 32'h80013344) $display("FAIL f3_011_word: got %h want 80013344", d);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic b0, b1; logic [31:0] d;
    do_store(32'h1004, 32'h1234, F3_W, b0);
    do_load(32'h4, F3_W, d, b0, b1);
    n_total++;
    if (d !== 32'h00001234) $display("FAIL wrap: got %h want 00001234", d);
    else n_pass++;
  endtask

`ifndef DMEM_MISALIGN_TRAP_EN
  task automatic test_truncate();
    logic b0, b1; logic [31:0] d;
    do_load(32'h23, F3_H, d, b0, b1);
    n_total++;
    if (d !== 32'hFFFF8001) $display("FAIL trunc_lh: got %h want ffff8001", d);
    else n_pass++;
    do_load(32'h13, F3_W, d, b0, b1);
    n_total++;
    if (d !== 32'h80ADBEEF) $display("FAIL trunc_lw: got %h want 80adbeef", d);
    else n_pass++;
    do_load(32'h21, F3_B, d, b0, b1);
    n_total++;
    if (d !== 32'h00000033) $display("FAIL lb_pos: got %h want 00000033", d);
    else n_pass++;
  endtask
`endif

  task automatic test_back_to_back();
    logic b0, b1, b2, b3; logic [31:0] d0, d1;
    do_store(32'h14, 32'hCAFEF00D, F3_W, b0);
    do_load(32'h10, F3_W, d0, b0, b1);
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h14; Funct3M = F3_W;
    #1 b2 = MemBusyM;
    @(posedge clk); @(negedge clk);
    b3 = MemBusyM;
    d1 = ReadDataM;
    n_total++;
    if ({b0, b1, b2, b3} !== 4'b1010)
      $display("FAIL b2b_busy: got %b want 1010", {b0, b1, b2, b3});
    else n_pass++;
    n_total++;
    if (d0 !== 32'h80ADBEEF || d1 !== 32'hCAFEF00D)
      $display("FAIL b2b_data: got %h %h want 80adbeef cafef00d", d0, d1);
    else n_pass++;
    // Reset lands in the second READ with the load still held in M.
    reset = 1'b1;
    #1;
    n_total++;
    if (dut.r_state !== IDLE) $display("FAIL rst_read_state: got %0d want IDLE", dut.r_state);
    else n_pass++;
    n_total++;
    if (ReadDataM !== 32'h0 || MemBusyM !== 1'b0)
      $display("FAIL rst_read_out: got %h/%b want 00000000/0", ReadDataM, MemBusyM);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (ReadDataM !== 32'h0 || MemBusyM !== 1'b0 || dut.r_state !== IDLE)
      $display("FAIL rst_held: got %h/%b want 00000000/0", ReadDataM, MemBusyM);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; MemReqM = 1'b0;
    @(negedge clk);
    do_load(32'h14, F3_W, d1, b0, b1);
    n_total++;
    if (d1 !== 32'hCAFEF00D || {b0, b1} !== 2'b10)
      $display("FAIL post_rst_lw: got %h/%b want cafef00d/10", d1, {b0, b1});
    else n_pass++;
  endtask

`ifdef DMEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic b0, b1, e0, e1; logic [31:0] d;
    do_store(32'h11, 32'hFFFFFFFF, F3_W, b0);
    e0 = MemErrM;
    @(negedge clk);
    e1 = MemErrM;
    n_total++;
    if ({e0, e1} !== 2'b10) $display("FAIL mis_sw_err: got %b want 10", {e0, e1});
    else n_pass++;
    do_load(32'h10, F3_W, d, b0, b1);
    n_total++;
    if (d !== 32'h80ADBEEF) $display("FAIL mis_sw_mem: got %h want 80adbeef", d);
    else n_pass++;
    MemReqM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h11; Funct3M = F3_H;
    @(posedge clk); @(negedge clk);
    e0 = MemErrM;
    d  = ReadDataM;
    @(posedge clk); @(negedge clk);
    MemReqM = 1'b0;
    e1 = MemErrM;
    n_total++;
    if (d !== 32'h0 || {e0, e1} !== 2'b10)
      $display("FAIL mis_lh: got %h/%b want 00000000/10", d, {e0, e1});
    else n_pass++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_wrap();
`ifndef DMEM_MISALIGN_TRAP_EN
    test_truncate();
`endif
    test_back_to_back();
`ifdef DMEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RV32I core: the slave end of the Memory-stage load/store interface driven by the datapath's `ALUResultM` and `WriteDataM` outputs. The block holds a word-organised data RAM and performs byte/halfword/word stores with byte enables. Loads take one wait state, signalled through a stall output, and return data sign- or zero-extended on `ReadDataM`.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `ADDR_W`, default `$clog2(DEPTH_WORDS)`: word-index width; derived, not overridden.

- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `MemReqM`  in  1: a load or store is present in the Memory stage.
- `MemWriteM`  in  1: 1 means store, 0 means load; qualified by `MemReqM`.
- `Funct3M`  in  3: access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `ALUResultM`  in  32: byte address.
- `WriteDataM`  in  32: store data, right-justified (low-order bytes).
- `ReadDataM`  out  32: extended load data, valid in state READ.
- `MemBusyM`  out  1: stall request to the hazard unit (holds F/D/E/M).
- `MemErrM`  out  1: misalignment pulse; present only with `DMEM_MISALIGN_TRAP_EN`.

## Operation
- FSM has two states, IDLE and READ. Reset puts the FSM in IDLE and sets `ReadDataM`=0, `MemBusyM`=0 and `MemErrM`=0. RAM contents are not reset.
- Word index is `ALUResultM[ADDR_W+1:2]`. Upper address bits are ignored, so the address space wraps modulo `DEPTH_WORDS*4`. Byte offset is `ALUResultM[1:0]`.
- Store, accepted in IDLE with `MemReqM & MemWriteM`: the RAM is written at that clock edge. There is no busy and no state change.
  - SB enables the lane selected by `offset` and writes `WriteDataM[7:0]`.
  - SH enables lanes {1,0} or {3,2}, selected by `offset[1]`, and writes `WriteDataM[15:0]`.
  - SW enables all four lanes.
- Load, accepted in IDLE with `MemReqM & ~MemWriteM`:
  - `MemBusyM` is 1 combinationally in the same cycle.
  - The RAM read is registered; `offset` and `Funct3M` are latched.
  - The FSM moves to READ.
- READ: `ReadDataM` is the selected byte/halfword/word, extended per the latched funct3. `MemBusyM`=0. The FSM returns unconditionally to IDLE. The same instruction still sitting in M during READ is not re-issued.
- Funct3 encodings 011, 110 and 111 are treated as word accesses.
- Without the macro, misaligned accesses truncate the offset:
  - Halfword uses `offset[1]` only.
  - Word ignores `offset`.
- Store to address A, then a load of A in the next cycle, returns the stored data (write precedes the read edge).
- Reset asserted in READ: the FSM returns to IDLE immediately, `ReadDataM`=0, and the pending load is dropped.

## Timing
- Store latency: 0 stall cycles; data is visible to any load accepted on the following edge.
- Load latency: exactly 1 stall cycle. The pipeline advances at the end of the READ cycle.
- Back-to-back loads: each load costs one busy cycle. IDLE→READ→IDLE→READ.
- `MemBusyM` depends combinationally on `MemReqM`, `MemWriteM` and the state only. It has no path from `ReadDataM`.
- `ReadDataM` is held at its last value outside READ; the consumer samples it only in READ.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - Misalignment is halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - A misaligned store is suppressed (no byte enables).
  - A misaligned load still takes the READ cycle but returns 0.
  - `MemErrM` pulses 1 for exactly one cycle, the cycle after acceptance.
- Undefined: no `MemErrM` port, no detection logic, and the truncation rules above apply.

## Structure
- Package `dmem_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`) and the state enum `dmem_state_t {IDLE, READ}`.
- Sub-module `dmem_sram`: single-port array with a 4-bit byte-write-enable and a registered read port. Lane selection, extension and the FSM stay in `dmem_responder`.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10: `MemBusyM` is 1 for one cycle, and READ gives `ReadDataM`=0xDEADBEEF.
- SB 0x80 to 0x13, then LB 0x13 and LBU 0x13: 0xFFFFFF80 and 0x00000080. Word 0x10 reads 0x80ADBEEF.
- SH 0x8001 to 0x22, then LH 0x22 and LHU 0x22: 0xFFFF8001 and 0x00008001. Bytes 0x20/0x21 are unchanged.
- Address wrap (`DEPTH_WORDS`=1024): SW 0x1234 to 0x1004, then LW 0x4 returns 0x1234.
- Back-to-back LW 0x10, LW 0x14: the busy pattern is 1,0,1,0. Assert reset during the second READ: the FSM is IDLE, `ReadDataM`=0 and `MemBusyM`=0 while reset is held.
- With `DMEM_MISALIGN_TRAP_EN`: SW to 0x11 leaves memory unchanged and `MemErrM` pulses once. LH 0x11 returns 0 and `MemErrM` pulses once.
